// File: rtl/v_prot_pkg.sv
// ----------------------------------------------------------------------------
// v_prot_pkg
//   Shared types and helpers for the v_prot mux self-test sequencer.
//   - state_t : sequencer FSM states (IDLE -> RUN -> FIN -> IDLE)
//   - N_VEC   : number of {A,B,Sel} vectors walked per run
//   - exp_sal : expected output of the 2:1 mux for a packed {A,B,Sel} vector
// ----------------------------------------------------------------------------
package v_prot_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int N_VEC = 8;

    // idx packs {A,B,Sel} with A as MSB; the mux selects B when Sel=1.
    function automatic logic exp_sal(input logic [2:0] idx);
        return idx[0] ? idx[1] : idx[2];
    endfunction

endpackage

// File: rtl/v_prot_tmr.sv
// ----------------------------------------------------------------------------
// v_prot_tmr
//   Dwell timer: counts 0..DWELL-1 while enabled and wraps, flagging the last
//   cycle of each dwell on o_tc.
// Ports
//   i_clk   in  1  clock, rising edge
//   i_rst_n in  1  synchronous active-low reset
//   i_clr   in  1  synchronous clear (count forced to 0)
//   i_en    in  1  count enable
//   o_tc    out 1  terminal count: count == DWELL-1
// ----------------------------------------------------------------------------
module v_prot_tmr #(
    parameter int DWELL = 100,
    parameter int CNT_W = 7
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == CNT_W'(DWELL - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            // Wrap at the terminal count so consecutive dwells need no clear.
            r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/v_prot_seq.sv
// ----------------------------------------------------------------------------
// v_prot_seq
//   Self-test sequencer for the v_prot 2:1 mux (Sal = Sel ? B : A). On Start it
//   walks {A,B,Sel} through 000..111, holding each vector DWELL cycles, checks
//   the returned Sal on the last cycle of each dwell and counts mismatches.
// Ports
//   Clk     in   1  clock, rising edge
//   Rst_n   in   1  synchronous active-low reset
//   Start   in   1  run request, only honoured in IDLE
//   Sal     in   1  mux output returned from v_prot (combinational)
//   A,B,Sel out  1  mux stimulus, registered
//   Busy    out  1  high while vectors are being applied
//   Done    out  1  one-cycle pulse after the last vector is checked
//   Err     out  1  sticky mismatch flag for the current/last run
//   ErrCnt  out  4  mismatch count for the current/last run (0..8)
// ----------------------------------------------------------------------------
module v_prot_seq
    import v_prot_pkg::*;
#(
    parameter int DWELL = 100,
    parameter int CNT_W = 7
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Sal,
    output logic       A,
    output logic       B,
    output logic       Sel,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [3:0] ErrCnt
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic       r_err;
    logic [3:0] r_errcnt;

    logic       w_tc;
    logic       w_accept;
    logic       w_sample;
    logic       w_busy;
    logic       w_done;
    logic       w_tmr_clr;

    // Timer sits at 0 outside RUN so the first dwell of a run is full length.
    v_prot_tmr #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_tmr (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_clr   (w_tmr_clr),
        .i_en    (1'b1),
        .o_tc    (w_tc)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_RUN;
            S_RUN:   if (w_tc && (r_idx == 3'(N_VEC - 1))) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_accept  = 1'b0;
        w_sample  = 1'b0;
        w_tmr_clr = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_accept = Start;
            end
            S_RUN: begin
                w_busy    = 1'b1;
                w_sample  = w_tc;
                w_tmr_clr = 1'b0;
            end
            S_FIN: begin
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Vector index and error tally. idx naturally wraps 7->0 on the last
    // sample, so it is already 0 in FIN/IDLE and can drive A/B/Sel directly.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_errcnt <= '0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_errcnt <= '0;
        end else if (w_sample) begin
            r_idx <= r_idx + 3'd1;
            if (Sal != exp_sal(r_idx)) begin
                r_err    <= 1'b1;
                r_errcnt <= r_errcnt + 4'd1;
            end
        end
    end

    assign {A, B, Sel} = r_idx;
    assign Busy        = w_busy;
    assign Done        = w_done;
    assign Err         = r_err;
    assign ErrCnt      = r_errcnt;

endmodule

// File: tb/tb_v_prot_seq.sv
module tb_v_prot_seq;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] tt = 8'h00;
    logic       Sal;
    logic       A, B, Sel, Busy, Done, Err;
    logic [3:0] ErrCnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    // Device under check is modelled by a truth table indexed by {A,B,Sel}.
    assign Sal = tt[{A, B, Sel}];

    v_prot_seq #(.DWELL(D), .CNT_W(3)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Start  (Start),
        .Sal    (Sal),
        .A      (A),
        .B      (B),
        .Sel    (Sel),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err),
        .ErrCnt (ErrCnt)
    );

    // Truth table of a correct 2:1 mux: Sal = Sel ? B : A, vector = {A,B,Sel}.
    function automatic logic [7:0] golden();
        logic [7:0] g;
        logic a, b, s;
        for (int v = 0; v < 8; v++) begin
            a = ((v >> 2) & 1) != 0;
            b = ((v >> 1) & 1) != 0;
            s = (v & 1) != 0;
            g[v] = s ? b : a;
        end
        return g;
    endfunction

    // Mismatches among the first 'upto' vectors for a given DUT table.
    function automatic int mism(input logic [7:0] t, input int upto);
        logic [7:0] g;
        int c;
        g = golden();
        c = 0;
        for (int v = 0; v < upto; v++)
            if (t[v] !== g[v]) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Start a run and check every cycle against the behavioural timeline:
    // cycle t (1-based, after the accepting edge) shows vector (t-1)/D,
    // Done in cycle 8D+1, counts reflect vectors already sampled.
    task automatic run_check(input string name, input logic [7:0] table_in,
                             input int p1, input int p2, input int rst_at,
                             input bit hold);
        int         eVec, eCnt;
        logic       eBusy, eDone;
        logic [9:0] exp_v, got_v;
        tt    = table_in;
        Start = 1'b1;
        tick();
        if (!hold) Start = 1'b0;
        for (int t = 1; t <= 8 * D + 3; t++) begin
            if (rst_at > 0 && t > rst_at) begin
                eVec = 0; eBusy = 0; eDone = 0; eCnt = 0;
            end else if (t <= 8 * D) begin
                eVec = (t - 1) / D; eBusy = 1; eDone = 0; eCnt = mism(tt, (t - 1) / D);
            end else if (t == 8 * D + 1) begin
                eVec = 0; eBusy = 0; eDone = 1; eCnt = mism(tt, 8);
            end else if (hold && t == 8 * D + 3) begin
                eVec = 0; eBusy = 1; eDone = 0; eCnt = 0;
            end else begin
                eVec = 0; eBusy = 0; eDone = 0; eCnt = mism(tt, 8);
            end
            exp_v = {3'(eVec), eBusy, eDone, (eCnt != 0), 4'(eCnt)};
            got_v = {A, B, Sel, Busy, Done, Err, ErrCnt};
            n_vec++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got ABS=%b Busy=%b Done=%b Err=%b ErrCnt=%0d, expected ABS=%b Busy=%b Done=%b Err=%b ErrCnt=%0d",
                         name, t, got_v[9:7], got_v[6], got_v[5], got_v[4], got_v[3:0],
                         exp_v[9:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
            end
            if (t == p1 || t == p2) Start = 1'b1;
            else if (!hold)         Start = 1'b0;
            Rst_n = (t == rst_at) ? 1'b0 : 1'b1;
            tick();
        end
        Start = 1'b0;
        Rst_n = 1'b1;
    endtask

    task automatic check_idle_zero(input string name, input int cycles);
        logic [9:0] got_v;
        for (int i = 0; i < cycles; i++) begin
            tick();
            got_v = {A, B, Sel, Busy, Done, Err, ErrCnt};
            n_vec++;
            if (got_v !== 10'd0) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %b, expected all zero", name, i, got_v);
            end
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        Start = 1'b1;
        check_idle_zero("reset_held", 3);
        Rst_n = 1'b1;
        Start = 1'b0;
        check_idle_zero("reset_release", 3);
    endtask

    task automatic test_golden();
        run_check("golden", golden(), 0, 0, 0, 1'b0);
    endtask

    task automatic test_stuck0();
        run_check("stuck0", 8'h00, 0, 0, 0, 1'b0);
    endtask

    task automatic test_inverted_then_golden();
        run_check("inverted", ~golden(), 0, 0, 0, 1'b0);
        run_check("rerun_golden", golden(), 0, 0, 0, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_check("ignored_start", golden(), 5, 20, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        run_check("reset_mid_run", ~golden(), 0, 0, 5 * D + 2, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            run_check("random", 8'($urandom), 0, 0, 0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_check("back_to_back", 8'($urandom), 0, 0, 0, 1'b1);
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        check_idle_zero("after_b2b_reset", 2);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck0();
        test_inverted_then_golden();
        test_ignored_start();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
